// File: rtl/bit16_rc_adder_if.sv
// bit16_rc_adder_if
// Operand/result bundle for the registered 16-bit ripple-carry adder.
//   in_valid  : operands valid this cycle (master -> slave)
//   a, b      : 16-bit unsigned operands (master -> slave)
//   c_in      : carry into bit 0, only when BIT16ADDER_CIN_EN is defined
//   f         : 17-bit registered sum, f[16] is the carry out (slave -> master)
//   cin       : 17-bit registered carry chain, cin[i] = carry into bit i
//   out_valid : f/cin hold a new result (slave -> master)
// Optional feature macro: BIT16ADDER_CIN_EN.
interface bit16_rc_adder_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
`ifdef BIT16ADDER_CIN_EN
  logic        c_in;
`endif
  logic [16:0] f;
  logic [16:0] cin;
  logic        out_valid;

`ifdef BIT16ADDER_CIN_EN
  modport master (output in_valid, a, b, c_in, input f, cin, out_valid);
  modport slave  (input in_valid, a, b, c_in, output f, cin, out_valid);
`else
  modport master (output in_valid, a, b, input f, cin, out_valid);
  modport slave  (input in_valid, a, b, output f, cin, out_valid);
`endif
endinterface

// File: rtl/bit16_rc_adder.sv
// bit16_rc_adder
// Registered 16-bit ripple-carry adder built from 16 explicit full-adder
// cells so the internal carry chain can be observed on cin.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bit16_rc_adder_if.slave (in_valid, a, b, [c_in], f, cin, out_valid)
// Optional feature macro: BIT16ADDER_CIN_EN adds the c_in port driving the
// carry into bit 0; without it the chain starts from a constant 0.

// One-bit full adder cell.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module bit16_rc_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module bit16_rc_adder (
  input  logic             clk,
  input  logic             rst,
  bit16_rc_adder_if.slave  bus
);

  // c[i] is the carry into bit i; c[16] is the carry out of the chain.
  logic [16:0] c;
  logic [15:0] s;

  logic [16:0] f_q;
  logic [16:0] cin_q;
  logic        out_valid_q;

`ifdef BIT16ADDER_CIN_EN
  assign c[0] = bus.c_in;
`else
  assign c[0] = 1'b0;
`endif

  for (genvar i = 0; i < 16; i++) begin : g_fa
    bit16_rc_fa u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .c  (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Reset dominates in_valid, so an operand pair presented during reset is
  // dropped. Without in_valid the result registers hold and only out_valid
  // drops.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q         <= '0;
      cin_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      f_q         <= {c[16], s};
      cin_q       <= c;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.f         = f_q;
  assign bus.cin       = cin_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bit16_rc_adder.sv
// tb_bit16_rc_adder
// Self-checking bench for bit16_rc_adder: directed vectors with known
// answers, then randomized traffic compared to an arithmetic reference.
// Define BIT16ADDER_CIN_EN to exercise the c_in variant.
module tb_bit16_rc_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bit16_rc_adder_if bus ();

  bit16_rc_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: what the outputs must show after the next edge.
  logic [16:0] exp_f     = '0;
  logic [16:0] exp_cin   = '0;
  logic        exp_valid = 1'b0;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference, and compare all outputs.
  task automatic step(input logic r, input logic v, input logic [15:0] va,
                      input logic [15:0] vb, input logic vc, input string tag);
    logic [16:0] sum;
    rst          = r;
    bus.in_valid = v;
    bus.a        = va;
    bus.b        = vb;
`ifdef BIT16ADDER_CIN_EN
    bus.c_in     = vc;
`endif
    if (r) begin
      exp_f     = '0;
      exp_cin   = '0;
      exp_valid = 1'b0;
    end else if (v) begin
`ifdef BIT16ADDER_CIN_EN
      sum = 17'(va) + 17'(vb) + 17'(vc);
`else
      sum = 17'(va) + 17'(vb);
`endif
      exp_f     = sum;
      // The carry into each bit is whatever makes a^b^carry equal the sum bit.
      exp_cin   = 17'(va) ^ 17'(vb) ^ sum;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ".f"}, bus.f, exp_f);
    check({tag, ".cin"}, bus.cin, exp_cin);
    check({tag, ".valid"}, 17'(bus.out_valid), 17'(exp_valid));
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
`ifdef BIT16ADDER_CIN_EN
    bus.c_in     = 1'b0;
`endif

    // Reset with valid operands present: they must be dropped.
    step(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0, "rst0");
    step(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0, "rst1");
    check("rst.f_zero", bus.f, 17'h0);
    check("rst.cin_zero", bus.cin, 17'h0);

    // Nominal.
    step(1'b0, 1'b1, 16'd1000, 16'd2000, 1'b0, "nom");
    check("nom.f_const", bus.f, 17'h00BB8);
    check("nom.cin_const", bus.cin, 17'h00F80);

    // Full carry ripple.
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, "ripple");
    check("ripple.f_const", bus.f, 17'h10000);
    check("ripple.cin_const", bus.cin, 17'h1FFFE);

    // Maximum operands.
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "max");
    check("max.f_const", bus.f, 17'h1FFFE);
    check("max.cin_const", bus.cin, 17'h1FFFE);

    // Back-to-back then hold.
    step(1'b0, 1'b1, 16'd5, 16'd7, 1'b0, "b2b0");
    check("b2b0.f_const", bus.f, 17'd12);
    step(1'b0, 1'b1, 16'd9, 16'd9, 1'b0, "b2b1");
    check("b2b1.f_const", bus.f, 17'd18);
    step(1'b0, 1'b0, 16'hA5A5, 16'h5A5B, 1'b1, "hold");
    check("hold.f_const", bus.f, 17'd18);
    check("hold.valid_const", 17'(bus.out_valid), 17'h0);

`ifdef BIT16ADDER_CIN_EN
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "cin_en");
    check("cin_en.f_const", bus.f, 17'h10000);
    check("cin_en.cin_const", bus.cin, 17'h1FFFF);
`endif

    // Reset mid-stream after a valid result, then resume.
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 16'h0F0F, 16'h0101, 1'b1, "mid_rst");
    step(1'b0, 1'b1, 16'h0F0F, 16'h0101, 1'b1, "resume");

    // Randomized traffic with occasional idle cycles and resets.
    for (int i = 0; i < 400; i++) begin
      logic r, v, vc;
      logic [15:0] va, vb;
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      vc = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       begin va = 16'hFFFF; vb = 16'(1'($urandom)); end
        1:       begin va = 16'hFFFF; vb = 16'hFFFF; end
        default: begin va = 16'($urandom); vb = 16'($urandom); end
      endcase
      step(r, v, va, vb, vc, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
